// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retire buffer with multi-lane dispatch, CDB completion and mispredict flush
module reorder_buffer #(
  parameter int WAYS = 4,
  parameter int ROB_SIZE = 32,
  parameter int PRF = 64,
  localparam int P = $clog2(PRF),
  localparam int R = $clog2(ROB_SIZE)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WAYS-1:0]          dis_valid,
  input  logic [WAYS-1:0]          dis_wr,
  input  logic [WAYS-1:0][4:0]     dis_arf,
  input  logic [WAYS-1:0][P-1:0]   dis_prf,
  output logic [WAYS-1:0]          dis_ready,
  output logic [WAYS-1:0][R-1:0]   dis_rob_idx,
  input  logic [WAYS-1:0]          cdb_valid,
  input  logic [WAYS-1:0][R-1:0]   cdb_rob_idx,
  input  logic [WAYS-1:0]          cdb_mispredict,
  output logic [WAYS-1:0]          retire_en,
  output logic [WAYS-1:0]          retire_wr,
  output logic [WAYS-1:0][4:0]     retire_arf,
  output logic [WAYS-1:0][P-1:0]   retire_prf,
  output logic                     except
);
  logic [R-1:0] head, tail;
  logic [R:0] count, free, n_acc, n_ret;
  logic [ROB_SIZE-1:0] occ, comp, misp, wr_q;
  logic [4:0] arf_q [ROB_SIZE];
  logic [P-1:0] prf_q [ROB_SIZE];
  logic [WAYS-1:0] acc;
  logic [R-1:0] hidx [WAYS];
  logic go, ok;
  always_comb begin
    free = (R+1)'(ROB_SIZE) - count;
    n_acc = '0;
    n_ret = '0;
    except = 1'b0;
    go = 1'b1;
    for (int i = 0; i < WAYS; i++) begin
      hidx[i] = head + R'(i);
      retire_en[i] = go & occ[hidx[i]] & comp[hidx[i]];
      go = retire_en[i] & ~misp[hidx[i]];
      except = except | (retire_en[i] & misp[hidx[i]]);
      n_ret = n_ret + (R+1)'(retire_en[i]);
      retire_wr[i] = retire_en[i] & wr_q[hidx[i]] & (|arf_q[hidx[i]]);
      retire_arf[i] = retire_en[i] ? arf_q[hidx[i]] : '0;
      retire_prf[i] = retire_en[i] ? prf_q[hidx[i]] : '0;
    end
    // dispatch lanes are accepted only as an unbroken run from lane 0
    ok = ~except;
    for (int i = 0; i < WAYS; i++) begin
      dis_rob_idx[i] = tail + R'(i);
      dis_ready[i] = free > (R+1)'(i);
      acc[i] = ok & dis_valid[i] & dis_ready[i];
      ok = acc[i];
      n_acc = n_acc + (R+1)'(acc[i]);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      occ <= '0;
      comp <= '0;
      misp <= '0;
    end else begin
      for (int i = 0; i < WAYS; i++)
        if (cdb_valid[i] && occ[cdb_rob_idx[i]]) begin
          comp[cdb_rob_idx[i]] <= 1'b1;
          misp[cdb_rob_idx[i]] <= cdb_mispredict[i];
        end
      for (int i = 0; i < WAYS; i++)
        if (retire_en[i]) begin
          occ[hidx[i]] <= 1'b0;
          comp[hidx[i]] <= 1'b0;
          misp[hidx[i]] <= 1'b0;
        end
      if (except) begin
        head <= head + R'(n_ret);
        tail <= head + R'(n_ret);
        count <= '0;
        occ <= '0;
        comp <= '0;
        misp <= '0;
      end else begin
        head <= head + R'(n_ret);
        tail <= tail + R'(n_acc);
        count <= count + n_acc - n_ret;
        for (int i = 0; i < WAYS; i++)
          if (acc[i]) begin
            occ[dis_rob_idx[i]] <= 1'b1;
            comp[dis_rob_idx[i]] <= 1'b0;
            misp[dis_rob_idx[i]] <= 1'b0;
            wr_q[dis_rob_idx[i]] <= dis_wr[i];
            arf_q[dis_rob_idx[i]] <= dis_arf[i];
            prf_q[dis_rob_idx[i]] <= dis_prf[i];
          end
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and random stimulus checked against a queue-based model of the buffer
module tb_reorder_buffer;
  localparam int W = 4, RS = 32, PR = 64, P = 6, R = 5;
  logic clock = 0, reset = 1;
  logic [W-1:0] dis_valid = '0, dis_wr = '0, dis_ready, cdb_valid = '0, cdb_mispredict = '0;
  logic [W-1:0] retire_en, retire_wr;
  logic except;
  logic [W-1:0][4:0] dis_arf = '0, retire_arf;
  logic [W-1:0][P-1:0] dis_prf = '0, retire_prf;
  logic [W-1:0][R-1:0] dis_rob_idx, cdb_rob_idx = '0;
  int checks = 0, failures = 0;
  typedef struct {logic wr; logic [4:0] arf; logic [P-1:0] prf; bit done; bit mis;} ent_t;
  ent_t q[$];
  int mhead = 0;

  reorder_buffer #(.WAYS(W), .ROB_SIZE(RS), .PRF(PR)) dut (
    .clock(clock), .reset(reset), .dis_valid(dis_valid), .dis_wr(dis_wr), .dis_arf(dis_arf),
    .dis_prf(dis_prf), .dis_ready(dis_ready), .dis_rob_idx(dis_rob_idx), .cdb_valid(cdb_valid),
    .cdb_rob_idx(cdb_rob_idx), .cdb_mispredict(cdb_mispredict), .retire_en(retire_en),
    .retire_wr(retire_wr), .retire_arf(retire_arf), .retire_prf(retire_prf), .except(except)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mt(int j);
    return (mhead + j) % RS;
  endfunction

  function automatic int mtail();
    return (mhead + q.size()) % RS;
  endfunction

  task automatic clr();
    dis_valid = '0;
    dis_wr = '0;
    cdb_valid = '0;
    cdb_mispredict = '0;
  endtask

  task automatic disp(input int n, input int arf, input int prf);
    for (int i = 0; i < W; i++) begin
      dis_valid[i] = i < n;
      dis_wr[i] = 1'b1;
      dis_arf[i] = 5'(arf + i);
      dis_prf[i] = P'(prf + i);
    end
  endtask

  task automatic cdb_at(input int lane, input int tag, input bit mis);
    cdb_valid[lane] = 1'b1;
    cdb_rob_idx[lane] = R'(tag);
    cdb_mispredict[lane] = mis;
  endtask

  task automatic model_reset();
    q.delete();
    mhead = 0;
  endtask

  // compare against the model, then advance the model and the clock by one cycle
  task automatic step();
    logic [W-1:0] e_rdy, e_en, e_wr;
    logic [W-1:0][R-1:0] e_idx;
    logic [W-1:0][4:0] e_arf;
    logic [W-1:0][P-1:0] e_prf;
    logic e_exc;
    int nret, nacc, free;
    e_en = '0; e_wr = '0; e_arf = '0; e_prf = '0; e_exc = 1'b0; nret = 0; nacc = 0;
    free = RS - q.size();
    for (int i = 0; i < W; i++) begin
      e_rdy[i] = free >= i + 1;
      e_idx[i] = R'((mhead + q.size() + i) % RS);
    end
    for (int j = 0; j < W && j < q.size(); j++) begin
      if (!q[j].done) break;
      e_en[j] = 1'b1;
      e_wr[j] = q[j].wr && q[j].arf != 0;
      e_arf[j] = q[j].arf;
      e_prf[j] = q[j].prf;
      nret++;
      if (q[j].mis) begin
        e_exc = 1'b1;
        break;
      end
    end
    chk("dis_ready", 64'(dis_ready), 64'(e_rdy));
    chk("dis_rob_idx", 64'(dis_rob_idx), 64'(e_idx));
    chk("retire_en", 64'(retire_en), 64'(e_en));
    chk("retire_wr", 64'(retire_wr), 64'(e_wr));
    chk("retire_arf", 64'(retire_arf), 64'(e_arf));
    chk("retire_prf", 64'(retire_prf), 64'(e_prf));
    chk("except", 64'(except), 64'(e_exc));
    if (!e_exc)
      for (int i = 0; i < W; i++)
        if (dis_valid[i] && free >= i + 1) nacc++;
        else break;
    for (int k = 0; k < nret; k++) q.delete(0);
    for (int i = 0; i < W; i++)
      if (cdb_valid[i]) begin
        int p;
        p = (int'(cdb_rob_idx[i]) - mhead + RS) % RS - nret;
        if (p >= 0 && p < q.size()) begin
          q[p].done = 1;
          q[p].mis = cdb_mispredict[i];
        end
      end
    mhead = (mhead + nret) % RS;
    if (e_exc) q.delete();
    else
      for (int i = 0; i < nacc; i++)
        q.push_back('{dis_wr[i], dis_arf[i], dis_prf[i], 1'b0, 1'b0});
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      clr();
      for (int i = 0; i < W && i < q.size(); i++) cdb_at(i, mt(i), 0);
      step();
    end
    clr();
  endtask

  initial begin
    int e;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    model_reset();
    chk("rst_ready", 64'(dis_ready), 64'(4'b1111));
    chk("rst_idx", 64'(dis_rob_idx), 64'({5'd3, 5'd2, 5'd1, 5'd0}));
    chk("rst_en", 64'(retire_en), 64'(0));
    chk("rst_wr", 64'(retire_wr), 64'(0));
    chk("rst_exc", 64'(except), 64'(0));

    disp(4, 1, 32); step();
    clr(); for (int i = 0; i < W; i++) cdb_at(i, i, 0); step();
    chk("r18_en", 64'(retire_en), 64'(4'b1111));
    chk("r18_prf", 64'(retire_prf), 64'({6'd35, 6'd34, 6'd33, 6'd32}));
    chk("r18_wr", 64'(retire_wr), 64'(4'b1111));
    clr(); step();
    chk("r18_empty_rdy", 64'(dis_ready), 64'(4'b1111));
    chk("r18_empty_idx", 64'(dis_rob_idx), 64'({5'd7, 5'd6, 5'd5, 5'd4}));
    chk("r18_empty_en", 64'(retire_en), 64'(0));

    disp(1, 0, 5); step();
    clr(); cdb_at(0, 4, 0); step();
    chk("r23_en", 64'(retire_en), 64'(4'b0001));
    chk("r23_wr", 64'(retire_wr), 64'(0));
    clr(); step();

    disp(4, 7, 40); step();
    clr(); for (int i = 1; i < W; i++) cdb_at(i, mt(i), 0); step();
    chk("r19_hold", 64'(retire_en), 64'(0));
    clr(); step();
    chk("r19_hold2", 64'(retire_en), 64'(0));
    cdb_at(0, mt(0), 0); step();
    chk("r19_en", 64'(retire_en), 64'(4'b1111));
    chk("r19_prf", 64'(retire_prf), 64'({6'd43, 6'd42, 6'd41, 6'd40}));
    clr(); step();

    disp(4, 1, 10); step();
    clr(); for (int i = 0; i < W; i++) cdb_at(i, mt(i), i == 1); step();
    chk("r21_en", 64'(retire_en), 64'(4'b0011));
    chk("r21_exc", 64'(except), 64'(1));
    e = (mhead + 2) % RS;
    disp(4, 20, 50); step();
    chk("r21_idx", 64'(dis_rob_idx[0]), 64'(e));
    chk("r21_rdy", 64'(dis_ready), 64'(4'b1111));
    chk("r21_en_after", 64'(retire_en), 64'(0));
    clr();

    for (int k = 0; k < 8; k++) begin disp(4, k, 4 * k); step(); end
    chk("r20_full", 64'(dis_ready), 64'(0));
    disp(4, 9, 9); step();
    clr(); cdb_at(0, mt(0), 0); cdb_at(1, mt(1), 0); step();
    chk("r20_ret", 64'(retire_en), 64'(4'b0011));
    chk("r20_still_full", 64'(dis_ready), 64'(0));
    clr(); step();
    chk("r20_rdy", 64'(dis_ready), 64'(4'b0011));
    drain();

    for (int k = 0; k < 20 && mtail() != 30; k++) begin
      int n;
      n = (30 - mtail() + RS) % RS;
      if (n > 4) n = 4;
      clr(); disp(n, 3, 3); step();
      drain();
    end
    chk("r22_idx", 64'(dis_rob_idx), 64'({5'd1, 5'd0, 5'd31, 5'd30}));
    disp(4, 5, 20); step();
    clr(); for (int i = 0; i < W; i++) cdb_at(i, mt(3 - i), 0); step();
    chk("r22_en", 64'(retire_en), 64'(4'b1111));
    chk("r22_prf", 64'(retire_prf), 64'({6'd23, 6'd22, 6'd21, 6'd20}));
    drain();

    for (int k = 0; k < 400; k++) begin
      dis_valid = 4'($urandom);
      dis_wr = 4'($urandom);
      dis_arf = 20'($urandom);
      dis_prf = 24'($urandom);
      cdb_valid = 4'($urandom);
      for (int i = 0; i < W; i++) begin
        cdb_rob_idx[i] = (q.size() > 0 && $urandom % 4 != 0) ? R'(mt($urandom_range(0, q.size() - 1))) : R'($urandom);
        cdb_mispredict[i] = ($urandom % 20) == 0;
      end
      step();
    end

    clr(); disp(4, 1, 1); step(); step();
    reset = 1;
    dis_valid = 4'b1111;
    cdb_valid = 4'b1111;
    @(posedge clock);
    #1;
    reset = 0;
    clr();
    model_reset();
    chk("mid_rst_ready", 64'(dis_ready), 64'(4'b1111));
    chk("mid_rst_idx", 64'(dis_rob_idx), 64'({5'd3, 5'd2, 5'd1, 5'd0}));
    chk("mid_rst_en", 64'(retire_en), 64'(0));
    chk("mid_rst_exc", 64'(except), 64'(0));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
